// File: rtl/nibble_serial_adder_ctrl_if.sv
// Handshake and operand/result bundle for the nibble-serial adder controller.
// The master side issues operands; the slave side returns the registered result.
interface nibble_serial_adder_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide adder built from one shared 4-bit ripple adder, stepping one nibble
// per clock from the LSB, with the carry held in a register between steps.
module ripple_carry_adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[4];
endmodule

module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    nibble_serial_adder_ctrl_if.slave  bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [W-1:0]  opa;
    logic [W-1:0]  opb;
    logic          carry;
    logic [IW-1:0] idx;
    logic [W-1:0]  result;
    logic          carryout;
    logic          busy_reg;
    logic          done_reg;

    logic [3:0]    anib;
    logic [3:0]    bnib;
    logic [3:0]    nsum;
    logic          ncout;

    // Constant-index mux keeps every part-select in range, even for NIBBLES=1.
    always_comb begin
        anib = '0;
        bnib = '0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (idx == IW'(n)) begin
                anib = opa[4*n +: 4];
                bnib = opb[4*n +: 4];
            end
        end
    end

    ripple_carry_adder_4bit u_adder (
        .a    (anib),
        .b    (bnib),
        .cin  (carry),
        .sum  (nsum),
        .cout (ncout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            opa      <= '0;
            opb      <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            result   <= '0;
            carryout <= 1'b0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        opa      <= bus.a;
                        opb      <= bus.b;
                        carry    <= bus.cin;
                        result   <= '0;
                        carryout <= 1'b0;
                        idx      <= '0;
                        busy_reg <= 1'b1;
                        state    <= RUN;
                    end else begin
                        busy_reg <= 1'b0;
                        state    <= IDLE;
                    end
                end
                RUN: begin
                    for (int n = 0; n < NIBBLES; n++) begin
                        if (idx == IW'(n)) begin
                            result[4*n +: 4] <= nsum;
                        end
                    end
                    carry <= ncout;
                    if (idx == LAST) begin
                        carryout <= ncout;
                        busy_reg <= 1'b0;
                        done_reg <= 1'b1;
                        state    <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.sum  = result;
    assign bus.cout = carryout;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl at NIBBLES = 1, 4 and 8: directed vector
// table, hand-written multi-cycle sequences and a randomized sweep.
module tb_nibble_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    nibble_serial_adder_ctrl_if #(.NIBBLES(1)) if1 ();
    nibble_serial_adder_ctrl_if #(.NIBBLES(4)) if4 ();
    nibble_serial_adder_ctrl_if #(.NIBBLES(8)) if8 ();

    nibble_serial_adder_ctrl #(.NIBBLES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    nibble_serial_adder_ctrl #(.NIBBLES(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    nibble_serial_adder_ctrl #(.NIBBLES(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

    int vecs = 0;
    int miscompares = 0;

    typedef struct {
        int          which;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] expSum;
        logic        expCout;
        logic        checkPartial;
        logic [31:0] expPartial;
    } vec_t;

    vec_t vectors [8];

    function automatic logic [31:0] mask(int which);
        return (which == 8) ? 32'hFFFF_FFFF : ((32'd1 << (4 * which)) - 32'd1);
    endfunction

    // Reference: plain (W+1)-bit addition of the masked operands.
    function automatic void refAdd(int which, logic [31:0] av, logic [31:0] bv, logic c,
                                   output logic [31:0] s, output logic co);
        logic [32:0] t;
        t  = {1'b0, av & mask(which)} + {1'b0, bv & mask(which)} + 33'(c);
        s  = t[31:0] & mask(which);
        co = t[4 * which];
    endfunction

    task automatic setIn(int which, logic st, logic [31:0] av, logic [31:0] bv, logic c);
        case (which)
            1: begin if1.start = st; if1.a = av[3:0];  if1.b = bv[3:0];  if1.cin = c; end
            4: begin if4.start = st; if4.a = av[15:0]; if4.b = bv[15:0]; if4.cin = c; end
            default: begin if8.start = st; if8.a = av; if8.b = bv; if8.cin = c; end
        endcase
    endtask

    task automatic setStart(int which, logic st);
        case (which)
            1: if1.start = st;
            4: if4.start = st;
            default: if8.start = st;
        endcase
    endtask

    task automatic getOut(int which, output logic bz, output logic dn,
                          output logic [31:0] s, output logic co);
        s = '0;
        case (which)
            1: begin bz = if1.busy; dn = if1.done; s[3:0]  = if1.sum; co = if1.cout; end
            4: begin bz = if4.busy; dn = if4.done; s[15:0] = if4.sum; co = if4.cout; end
            default: begin bz = if8.busy; dn = if8.done; s = if8.sum; co = if8.cout; end
        endcase
    endtask

    task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
        vecs++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Called one step after the accepting edge; returns edges until done (-1 on timeout).
    task automatic waitDone(int which, output int lat, output int busyCnt,
                            output logic [31:0] partial, output logic busyAtDone,
                            output logic [31:0] s, output logic co);
        logic bz, dn;
        lat = -1; busyCnt = 0; partial = '0; busyAtDone = 1'b1; s = '0; co = 1'b0;
        for (int e = 0; e <= 40; e++) begin
            getOut(which, bz, dn, s, co);
            if (e == 1) partial = s;
            if (dn) begin
                lat = e;
                busyAtDone = bz;
                break;
            end
            if (bz) busyCnt++;
            @(posedge clk); #1;
        end
    endtask

    // Accept one operation, scramble the inputs while it runs, and check the result.
    task automatic applyStimulus(string tag, int which, logic [31:0] av, logic [31:0] bv,
                                 logic c, logic [31:0] expS, logic expC,
                                 logic chkPartial, logic [31:0] expPartial);
        int lat, busyCnt;
        logic [31:0] partial, s;
        logic co, busyAtDone, bz, dn;
        setIn(which, 1'b1, av, bv, c);
        @(posedge clk); #1;
        setIn(which, 1'b0, $urandom, $urandom, 1'($urandom));
        waitDone(which, lat, busyCnt, partial, busyAtDone, s, co);
        checkOutput($sformatf("%s latency", tag), 64'(lat), 64'(which));
        checkOutput($sformatf("%s busy cycles", tag), 64'(busyCnt), 64'(which));
        checkOutput($sformatf("%s busy at done", tag), 64'(busyAtDone), 64'd0);
        checkOutput($sformatf("%s sum", tag), 64'(s), 64'(expS));
        checkOutput($sformatf("%s cout", tag), 64'(co), 64'(expC));
        if (chkPartial) checkOutput($sformatf("%s partial", tag), 64'(partial), 64'(expPartial));
        @(posedge clk); #1;
        getOut(which, bz, dn, s, co);
        checkOutput($sformatf("%s done width", tag), 64'(dn), 64'd0);
        checkOutput($sformatf("%s sum hold", tag), 64'(s), 64'(expS));
    endtask

    initial begin
        logic bz, dn, co, busyAtDone;
        logic [31:0] s, partial, ra, rb, rs;
        logic rc, rco;
        int lat, busyCnt, doneCount;
        int sizes [2];

        vectors[0] = '{4, 32'hFFFF,     32'h0001,     1'b0, 32'h0000,     1'b1, 1'b1, 32'h0000};
        vectors[1] = '{4, 32'h1234,     32'h4321,     1'b1, 32'h5556,     1'b0, 1'b1, 32'h0006};
        vectors[2] = '{1, 32'h9,        32'h8,        1'b1, 32'h2,        1'b1, 1'b0, 32'h0};
        vectors[3] = '{1, 32'hF,        32'hF,        1'b1, 32'hF,        1'b1, 1'b0, 32'h0};
        vectors[4] = '{8, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b1, 32'h0};
        vectors[5] = '{8, 32'h12345678, 32'h87654321, 1'b1, 32'h9999999A, 1'b0, 1'b1, 32'hA};
        vectors[6] = '{4, 32'h0000,     32'h0000,     1'b0, 32'h0000,     1'b0, 1'b0, 32'h0};
        vectors[7] = '{4, 32'h0F0F,     32'h00F1,     1'b0, 32'h1000,     1'b0, 1'b1, 32'h0000};

        rst = 1'b1;
        setIn(1, 1'b0, 0, 0, 1'b0);
        setIn(4, 1'b0, 0, 0, 1'b0);
        setIn(8, 1'b0, 0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (sizes[i]) sizes[i] = 4 * (i + 1);
        for (int w = 0; w < 3; w++) begin
            int which;
            which = (w == 0) ? 1 : ((w == 1) ? 4 : 8);
            getOut(which, bz, dn, s, co);
            checkOutput($sformatf("reset busy N%0d", which), 64'(bz), 64'd0);
            checkOutput($sformatf("reset done N%0d", which), 64'(dn), 64'd0);
            checkOutput($sformatf("reset sum N%0d",  which), 64'(s),  64'd0);
            checkOutput($sformatf("reset cout N%0d", which), 64'(co), 64'd0);
        end

        for (int i = 0; i < 8; i++) begin
            applyStimulus($sformatf("vec%0d", i), vectors[i].which, vectors[i].a, vectors[i].b,
                          vectors[i].cin, vectors[i].expSum, vectors[i].expCout,
                          vectors[i].checkPartial, vectors[i].expPartial);
        end

        // Start held high through RUN while operands churn: one result, one done.
        setIn(4, 1'b1, 32'h1111, 32'h2222, 1'b0);
        @(posedge clk); #1;
        busyCnt = 0;
        for (int i = 0; i < 4; i++) begin
            getOut(4, bz, dn, s, co);
            if (bz) busyCnt++;
            setIn(4, 1'b1, $urandom, $urandom, 1'($urandom));
            @(posedge clk); #1;
        end
        getOut(4, bz, dn, s, co);
        setStart(4, 1'b0);
        checkOutput("hold busy cycles", 64'(busyCnt), 64'd4);
        checkOutput("hold done", 64'(dn), 64'd1);
        checkOutput("hold sum", 64'(s), 64'h3333);
        checkOutput("hold cout", 64'(co), 64'd0);
        doneCount = dn ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            getOut(4, bz, dn, s, co);
            if (dn) doneCount++;
        end
        checkOutput("hold done count", 64'(doneCount), 64'd1);
        checkOutput("hold idle busy", 64'(bz), 64'd0);

        // Back-to-back: new start asserted during the DONE cycle.
        setIn(4, 1'b1, 32'h0001, 32'h0002, 1'b0);
        @(posedge clk); #1;
        setStart(4, 1'b0);
        waitDone(4, lat, busyCnt, partial, busyAtDone, s, co);
        checkOutput("b2b first latency", 64'(lat), 64'd4);
        checkOutput("b2b first sum", 64'(s), 64'h0003);
        setIn(4, 1'b1, 32'h8000, 32'h8000, 1'b0);
        @(posedge clk); #1;
        getOut(4, bz, dn, s, co);
        checkOutput("b2b busy", 64'(bz), 64'd1);
        checkOutput("b2b done low", 64'(dn), 64'd0);
        checkOutput("b2b sum cleared", 64'(s), 64'd0);
        setIn(4, 1'b0, $urandom, $urandom, 1'b1);
        waitDone(4, lat, busyCnt, partial, busyAtDone, s, co);
        checkOutput("b2b second latency", 64'(lat), 64'd4);
        checkOutput("b2b second sum", 64'(s), 64'h0000);
        checkOutput("b2b second cout", 64'(co), 64'd1);
        @(posedge clk); #1;

        // Reset two edges into an operation, with start raised on the reset edge.
        setIn(4, 1'b1, 32'hFFFF, 32'hFFFF, 1'b1);
        @(posedge clk); #1;
        setStart(4, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        setStart(4, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        setStart(4, 1'b0);
        getOut(4, bz, dn, s, co);
        checkOutput("rst busy", 64'(bz), 64'd0);
        checkOutput("rst done", 64'(dn), 64'd0);
        checkOutput("rst sum", 64'(s), 64'd0);
        checkOutput("rst cout", 64'(co), 64'd0);
        doneCount = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            getOut(4, bz, dn, s, co);
            if (dn || bz) doneCount++;
        end
        checkOutput("rst no activity", 64'(doneCount), 64'd0);
        applyStimulus("post-rst", 4, 32'h0F0F, 32'h00F1, 1'b0, 32'h1000, 1'b0, 1'b0, 32'h0);

        // Randomized sweep against the arithmetic reference.
        foreach (sizes[k]) begin
            for (int i = 0; i < 500; i++) begin
                ra = $urandom;
                rb = $urandom;
                rc = 1'($urandom);
                refAdd(sizes[k], ra, rb, rc, rs, rco);
                applyStimulus($sformatf("rand N%0d #%0d", sizes[k], i), sizes[k], ra, rb, rc,
                              rs, rco, 1'b0, 32'h0);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end
endmodule
